// File: rtl/t5_decd.sv
// t5_decd: decode stage of the 4-hart barrel RV32I pipeline.
// Registers the fetched word and hart-tagged PC, extracts register/function
// fields, builds the sign-extended immediate, classifies legality and
// register write, and keeps a RUN/HALT state per hart.
// Optional feature macro: T5_CSR_EN (legal Zicsr SYSTEM encodings).
module t5_decd #(
    parameter int XLEN = 32  // only 32 is supported
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ena,
    input  logic [31:0]     idat,
    input  logic [XLEN-1:0] pc,
    input  logic [3:0]      resume,
    output logic [XLEN-1:0] dpc,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic [2:0]      fn3,
    output logic            fn7b,
    output logic [4:0]      opc,
    output logic [31:0]     imm,
    output logic            vld,
    output logic            wre,
    output logic            trp,
    output logic [3:0]      halt
);

    typedef enum logic [4:0] {
        OP_LOAD   = 5'b00000,
        OP_MISC   = 5'b00011,
        OP_OPIMM  = 5'b00100,
        OP_AUIPC  = 5'b00101,
        OP_STORE  = 5'b01000,
        OP_OP     = 5'b01100,
        OP_LUI    = 5'b01101,
        OP_BRANCH = 5'b11000,
        OP_JALR   = 5'b11001,
        OP_JAL    = 5'b11011,
        OP_SYSTEM = 5'b11100
    } opcode_e;

    typedef enum logic {
        S_RUN  = 1'b0,
        S_HALT = 1'b1
    } hart_st_e;

    hart_st_e st_q [4];
    hart_st_e st_d [4];

    logic [XLEN-1:0] dpc_q, dpc_d;
    logic [4:0]      rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d, opc_q, opc_d;
    logic [2:0]      fn3_q, fn3_d;
    logic            fn7b_q, fn7b_d;
    logic [31:0]     imm_q, imm_d;
    logic            vld_q, vld_d, wre_q, wre_d, trp_q, trp_d;

    logic [1:0]  hid;
    logic [31:0] imm_n;
    logic        legal, wr_cls, is_env, trap_c, wr_c, run_c;

    assign hid = pc[1:0];

    // Instruction classification and immediate generation
    always_comb begin
        imm_n  = '0;
        legal  = 1'b0;
        wr_cls = 1'b0;
        is_env = 1'b0;
        case (opcode_e'(idat[6:2]))
            OP_LOAD, OP_OPIMM: begin
                imm_n  = {{20{idat[31]}}, idat[31:20]};
                legal  = 1'b1;
                wr_cls = 1'b1;
            end
            OP_JALR: begin
                imm_n  = {{20{idat[31]}}, idat[31:20]};
                legal  = (idat[14:12] == 3'b000);
                wr_cls = 1'b1;
            end
            OP_SYSTEM: begin
                imm_n = {{20{idat[31]}}, idat[31:20]};
                if (idat == 32'h0000_0073 || idat == 32'h0010_0073) begin
                    legal  = 1'b1;
                    is_env = 1'b1;
                end
`ifdef T5_CSR_EN
                else if (idat[14:12] != 3'b000 && idat[14:12] != 3'b100) begin
                    legal  = 1'b1;
                    wr_cls = 1'b1;
                end
`endif
            end
            OP_STORE: begin
                imm_n = {{20{idat[31]}}, idat[31:25], idat[11:7]};
                legal = 1'b1;
            end
            OP_BRANCH: begin
                imm_n = {{19{idat[31]}}, idat[31], idat[7], idat[30:25], idat[11:8], 1'b0};
                legal = (idat[14:12] != 3'b010) && (idat[14:12] != 3'b011);
            end
            OP_LUI, OP_AUIPC: begin
                imm_n  = {idat[31:12], 12'h000};
                legal  = 1'b1;
                wr_cls = 1'b1;
            end
            OP_JAL: begin
                imm_n  = {{11{idat[31]}}, idat[31], idat[19:12], idat[20], idat[30:21], 1'b0};
                legal  = 1'b1;
                wr_cls = 1'b1;
            end
            OP_OP: begin
                legal  = 1'b1;
                wr_cls = 1'b1;
            end
            OP_MISC: begin
                legal = 1'b1;
            end
            default: begin
                legal = 1'b0;
            end
        endcase
        if (idat[1:0] != 2'b11) begin
            legal = 1'b0;
        end
        trap_c = !legal || is_env;
        wr_c   = legal && wr_cls && (idat[11:7] != 5'd0);
    end

    // Per-hart next state: resume is honoured regardless of ena; a trap halts the issuing hart
    always_comb begin
        run_c = (st_q[hid] == S_RUN);
        for (int unsigned h = 0; h < 4; h++) begin
            st_d[h] = st_q[h];
            if (st_q[h] == S_HALT) begin
                if (resume[h]) begin
                    st_d[h] = S_RUN;
                end
            end else if (ena && hid == 2'(h) && trap_c) begin
                st_d[h] = S_HALT;
            end
        end
    end

    // Per-hart state register
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned h = 0; h < 4; h++) begin
                st_q[h] <= S_RUN;
            end
        end else begin
            for (int unsigned h = 0; h < 4; h++) begin
                st_q[h] <= st_d[h];
            end
        end
    end

    // Pipeline register next values: capture on ena, hold otherwise
    always_comb begin
        dpc_d  = dpc_q;
        rs1_d  = rs1_q;
        rs2_d  = rs2_q;
        rd_d   = rd_q;
        fn3_d  = fn3_q;
        fn7b_d = fn7b_q;
        opc_d  = opc_q;
        imm_d  = imm_q;
        vld_d  = vld_q;
        wre_d  = wre_q;
        trp_d  = trp_q;
        if (ena) begin
            dpc_d  = pc;
            rs1_d  = idat[19:15];
            rs2_d  = idat[24:20];
            rd_d   = idat[11:7];
            fn3_d  = idat[14:12];
            fn7b_d = idat[30];
            opc_d  = idat[6:2];
            imm_d  = imm_n;
            vld_d  = run_c && !trap_c;
            wre_d  = run_c && !trap_c && wr_c;
            trp_d  = run_c && trap_c;
        end
    end

    // Pipeline registers
    always_ff @(posedge clk) begin
        if (rst) begin
            dpc_q  <= '0;
            rs1_q  <= '0;
            rs2_q  <= '0;
            rd_q   <= '0;
            fn3_q  <= '0;
            fn7b_q <= 1'b0;
            opc_q  <= '0;
            imm_q  <= '0;
            vld_q  <= 1'b0;
            wre_q  <= 1'b0;
            trp_q  <= 1'b0;
        end else begin
            dpc_q  <= dpc_d;
            rs1_q  <= rs1_d;
            rs2_q  <= rs2_d;
            rd_q   <= rd_d;
            fn3_q  <= fn3_d;
            fn7b_q <= fn7b_d;
            opc_q  <= opc_d;
            imm_q  <= imm_d;
            vld_q  <= vld_d;
            wre_q  <= wre_d;
            trp_q  <= trp_d;
        end
    end

    // Output mapping; halt reflects the live hart state
    always_comb begin
        dpc  = dpc_q;
        rs1  = rs1_q;
        rs2  = rs2_q;
        rd   = rd_q;
        fn3  = fn3_q;
        fn7b = fn7b_q;
        opc  = opc_q;
        imm  = imm_q;
        vld  = vld_q;
        wre  = wre_q;
        trp  = trp_q;
        for (int unsigned h = 0; h < 4; h++) begin
            halt[h] = (st_q[h] == S_HALT);
        end
    end

endmodule

// File: doc/t5_decd.md
Name: t5_decd

Overview:
- Decode stage of the 4-hart barrel RV32I pipeline, directly downstream of instruction fetch.
- Registers the fetched instruction word together with its hart-tagged PC.
- Splits the word into register indices, function fields and a sign-extended immediate, and classifies it (legal, register write, trap).
- Keeps a per-hart RUN/HALT state so a hart that traps issues only bubbles until the debugger resumes it.

Parameters:
XLEN, 32, data/address width; the block supports only 32 (RV32I).

Ports:
clk     in   1      clock
rst     in   1      reset: synchronous, active-high
ena     in   1      pipeline advance; all pipeline regs and FSMs hold when low, except resume (below)
idat    in   32     fetched instruction word, aligned with pc in the same cycle
pc      in   XLEN   fetch PC; bits [1:0] carry the hart id, bits [XLEN-1:2] the word address
resume  in   4      per-hart resume request, one bit per hart
dpc     out  XLEN   registered copy of pc
rs1     out  5      idat[19:15]
rs2     out  5      idat[24:20]
rd      out  5      idat[11:7]
fn3     out  3      idat[14:12]
fn7b    out  1      idat[30]
opc     out  5      idat[6:2]
imm     out  32     sign-extended immediate
vld     out  1      instruction is valid to execute
wre     out  1      register write enable
trp     out  1      trap pulse for the hart in dpc[1:0]
halt    out  4      per-hart HALT state

Behaviour:
- Reset (rst=1 at clk edge): all outputs 0; every hart FSM goes to RUN. rst overrides ena and resume.
- Latency: 1 cycle. On each clk edge with ena=1, outputs reflect the idat/pc present at that edge. With ena=0, outputs hold.
- Field outputs (rs1, rs2, rd, fn3, fn7b, opc, dpc) are registered unconditionally on ena, even for bubbles.
- Immediate, selected by idat[6:2]:
  - I-type: LOAD 00000, OP-IMM 00100, JALR 11001, SYSTEM 11100 → sext(idat[31:20]).
  - S-type: STORE 01000 → sext({idat[31:25], idat[11:7]}).
  - B-type: BRANCH 11000 → sext({idat[31], idat[7], idat[30:25], idat[11:8], 1'b0}).
  - U-type: LUI 01101, AUIPC 00101 → {idat[31:12], 12'h000}.
  - J-type: JAL 11011 → sext({idat[31], idat[19:12], idat[20], idat[30:21], 1'b0}).
  - All other opcodes → imm = 0.
- Legality. An instruction is legal when idat[1:0]=11 and the opcode is one of:
  - LUI, AUIPC, JAL, JALR (fn3=000 only), BRANCH (fn3 not 010 or 011), LOAD, STORE, OP-IMM, OP, MISC-MEM (treated as a nop);
  - SYSTEM: only exactly ECALL 32'h00000073 or EBREAK 32'h00100073 (see Optional Feature).
- Trap condition: the instruction is illegal, ECALL, or EBREAK.
- wre = 1 for a legal instruction whose opcode is LUI, AUIPC, JAL, JALR, LOAD, OP-IMM or OP, with rd != 0, and only when vld=1.
- Per-hart FSM, hart h = pc[1:0]:
  - RUN: an incoming instruction gets vld=1 unless it meets the trap condition.
  - On a trap: vld=0, wre=0, trp=1 for one ena cycle, and hart h goes RUN→HALT at that edge. dpc holds the trapping PC.
  - HALT: instructions from hart h get vld=0, wre=0, trp=0.
  - HALT→RUN when resume[h]=1 at a clk edge. This is independent of ena.
  - resume[h] while the hart is in RUN is ignored.
  - If resume[h] is high in the same cycle a halted hart-h instruction is decoded, that instruction is still a bubble; the hart runs from its next slot.
- halt[h] = 1 exactly while hart h is in HALT. It updates on the same edge as trp.
- Harts are independent: a halt of one hart does not affect the vld of the others.
- rst asserted mid-operation clears all HALT states and drops vld, wre and trp to 0 on that edge.

Optional Feature:
- Macro: T5_CSR_EN.
- Defined: SYSTEM with fn3 in {001, 010, 011, 101, 110, 111} is legal. Its imm is the I-type value, i.e. the CSR address sext(idat[31:20]). wre = (rd != 0). ECALL and EBREAK still trap.
- Not defined: every SYSTEM encoding other than exact ECALL or EBREAK is illegal and traps.

Test Plan:
- Reset, then ena=1, pc=32'h00000100, idat=32'h00500093 (addi x1,x0,5) → next cycle: vld=1, wre=1, rd=1, rs1=0, imm=5, dpc=32'h100, trp=0.
- Hart 2, idat=32'hFE000EE3 (beq x0,x0,-4), pc=32'h00000042 → imm=32'hFFFFFFFC, vld=1, wre=0, opc=5'b11000.
- Hart 1, idat=32'h00100073 (EBREAK), pc=32'h00000205 → trp=1 for one cycle, vld=0, halt=4'b0010. Next hart-1 addi → vld=0, wre=0, trp=0. Hart-3 addi in between → vld=1.
- Halted hart 1: assert resume=4'b0010 with ena=0 for one cycle → halt=4'b0000. Next hart-1 addi → vld=1.
- idat=32'h00000000 (idat[1:0]=00) on hart 0 → trp=1, halt[0]=1. Assert rst one cycle later → halt=0, all outputs 0.
- idat=32'h300020F3 (csrrs x1,mstatus,x0): with T5_CSR_EN → vld=1, wre=1, imm=32'h00000300. Without it → trp=1, vld=0.
